fifo_rd_packer: RTL and testbench

Read-side consumer of the 16-entry asynchronous byte FIFO. It runs entirely in the read clock domain and drains the FIFO through its `re`/`empty`/`data_out` interface. It packs consecutive bytes into `WORD_BYTES`-wide words and presents them on a valid/ready stream to downstream logic. It sustains one FIFO read per cycle while the FIFO has data and the output is not back-pressured.

---
 rtl/fifo_rd_packer.sv | 130 +++++++++++++
 tb/tb_fifo_rd_packer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_packer.sv
// rtl/fifo_rd_packer.sv - drains a byte FIFO and packs bytes into WORD_BYTES-wide valid/ready words
// Optional idle flush of partial words is enabled by defining PACKER_TIMEOUT_EN.
module fifo_rd_packer #(
    parameter int WORD_BYTES = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic                    rd_clk,
    input  logic                    rd_rst,
    input  logic                    fifo_empty,
    input  logic [7:0]              fifo_data,
    output logic                    fifo_re,
    output logic [8*WORD_BYTES-1:0] m_data,
    output logic [WORD_BYTES-1:0]   m_keep,
    output logic                    m_valid,
    input  logic                    m_ready
);
    localparam int            CW   = $clog2(WORD_BYTES + 2);
    localparam logic [CW-1:0] FULL = CW'(WORD_BYTES);

    if (WORD_BYTES < 2 || WORD_BYTES > 8 || TIMEOUT < 1) begin : g_param_check
        $error("fifo_rd_packer: WORD_BYTES must be 2..8 and TIMEOUT at least 1");
    end

    logic [CW-1:0]           r_cnt;
    logic                    r_pend;
    logic [8*WORD_BYTES-1:0] r_asm;
    logic [8*WORD_BYTES-1:0] r_m_data;
    logic [WORD_BYTES-1:0]   r_m_keep;
    logic                    r_m_valid;

    logic [CW-1:0]           w_sum;
    logic                    w_out_free;
    logic                    w_xfer;
    logic                    w_flush;
    logic [CW-1:0]           w_cnt_nxt;
    logic [8*WORD_BYTES-1:0] w_asm_nxt;
    logic [8*WORD_BYTES-1:0] w_out_data;
    logic [WORD_BYTES-1:0]   w_out_keep;

    assign w_sum      = r_cnt + CW'(r_pend);
    assign w_out_free = !r_m_valid || m_ready;
    assign w_xfer     = (r_cnt == FULL) && w_out_free;

    // A read that will complete the word is allowed only when the output is free now,
    // which guarantees it is still free when the word fills, so reads never stall.
    assign fifo_re = !rd_rst && !fifo_empty && !w_flush &&
                     ((w_sum < FULL) || ((w_sum == FULL) && w_out_free) || w_xfer);

`ifdef PACKER_TIMEOUT_EN
    localparam int            IW       = $clog2(TIMEOUT + 1);
    localparam logic [IW-1:0] IDLE_MAX = IW'(TIMEOUT);

    logic [IW-1:0]           r_idle;
    logic [WORD_BYTES-1:0]   w_part_keep;
    logic [8*WORD_BYTES-1:0] w_part_data;

    assign w_flush = (r_idle == IDLE_MAX) && w_out_free && !r_pend && (r_cnt != '0);

    always_comb begin
        w_part_keep = '0;
        w_part_data = '0;
        for (int i = 0; i < WORD_BYTES; i++) begin
            w_part_keep[i]        = (CW'(i) < r_cnt);
            w_part_data[8*i +: 8] = w_part_keep[i] ? r_asm[8*i +: 8] : 8'h00;
        end
    end

    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            r_idle <= '0;
        end else if (r_pend || w_flush) begin
            r_idle <= '0;
        end else if ((r_cnt != '0) && (r_cnt < FULL) && fifo_empty && (r_idle != IDLE_MAX)) begin
            r_idle <= r_idle + IW'(1);
        end
    end
`else
    assign w_flush = 1'b0;
`endif

    always_comb begin
        w_out_data = r_asm;
        w_out_keep = '1;
`ifdef PACKER_TIMEOUT_EN
        if (!w_xfer) begin
            w_out_data = w_part_data;
            w_out_keep = w_part_keep;
        end
`endif
    end

    always_comb begin
        w_asm_nxt = r_asm;
        w_cnt_nxt = r_cnt;
        if (w_xfer || w_flush) begin
            w_cnt_nxt = '0;
        end
        // A byte arriving alongside a transfer starts the next word at lane 0.
        if (r_pend) begin
            w_asm_nxt[{w_cnt_nxt, 3'b000} +: 8] = fifo_data;
            w_cnt_nxt = w_cnt_nxt + CW'(1);
        end
    end

    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            r_cnt     <= '0;
            r_pend    <= 1'b0;
            r_asm     <= '0;
            r_m_data  <= '0;
            r_m_keep  <= '0;
            r_m_valid <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_pend <= fifo_re;
            r_asm  <= w_asm_nxt;
            if (w_xfer || w_flush) begin
                r_m_data  <= w_out_data;
                r_m_keep  <= w_out_keep;
                r_m_valid <= 1'b1;
            end else if (m_ready) begin
                r_m_valid <= 1'b0;
            end
        end
    end

    assign m_data  = r_m_data;
    assign m_keep  = r_m_keep;
    assign m_valid = r_m_valid;
endmodule

// File: tb/tb_fifo_rd_packer.sv
// tb/tb_fifo_rd_packer.sv - directed self-checking bench for fifo_rd_packer
module tb_fifo_rd_packer;
    localparam int WB = 4;

    logic        clk = 1'b0;
    logic        rd_rst;
    logic        fifo_empty;
    logic [7:0]  fifo_data = 8'h00;
    logic        fifo_re;
    logic [31:0] m_data;
    logic [3:0]  m_keep;
    logic        m_valid;
    logic        m_ready;

    logic [7:0]  src [0:2047];
    int          avail = 0;
    int          rd_ptr = 0;
    logic        gate_empty;
    logic [31:0] wlog [$];
    logic [3:0]  klog [$];
    logic [7:0]  obytes [$];
    int          n_cmp = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    assign fifo_empty = gate_empty || (rd_ptr >= avail);

    fifo_rd_packer #(.WORD_BYTES(WB), .TIMEOUT(16)) dut (
        .rd_clk     (clk),
        .rd_rst     (rd_rst),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_re    (fifo_re),
        .m_data     (m_data),
        .m_keep     (m_keep),
        .m_valid    (m_valid),
        .m_ready    (m_ready)
    );

    // FIFO read-side model and output word/byte collector
    always @(posedge clk) begin
        if (fifo_re && !fifo_empty) begin
            fifo_data <= src[rd_ptr];
            rd_ptr    <= rd_ptr + 1;
        end
        if (!rd_rst && m_valid && m_ready) begin
            wlog.push_back(m_data);
            klog.push_back(m_keep);
            for (int i = 0; i < WB; i++)
                if (m_keep[i]) obytes.push_back(m_data[8*i +: 8]);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] re_v;
        logic [11:0] val_v;
        logic [31:0] d6, d10, dw;
        logic [3:0]  k6, kw;
        int          rp0, base, bad, cyc, first;

        rd_rst = 1'b1; m_ready = 1'b1; gate_empty = 1'b0;
        for (int i = 0; i < 8; i++) src[i] = 8'(i + 1);
        avail = 8;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_fifo_re", fifo_re, 0);
        check("reset_m_valid", m_valid, 0);
        check("reset_m_keep", m_keep, 0);
        check("reset_m_data", m_data, 0);

        // 8 bytes, always ready
        @(posedge clk); #1 rd_rst = 1'b0;
        re_v = '0; val_v = '0; d6 = '0; d10 = '0; k6 = '0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            re_v[k]  = fifo_re;
            val_v[k] = m_valid;
            if (k == 6) begin d6 = m_data; k6 = m_keep; end
            if (k == 10) d10 = m_data;
        end
        check("stream_re_pattern", re_v, 12'h0FF);
        check("stream_valid_pattern", val_v, 12'h440);
        check("stream_word0", d6, 32'h04030201);
        check("stream_keep0", k6, 4'hF);
        check("stream_word1", d10, 32'h08070605);

        // back-pressure with 12 bytes available
        @(posedge clk); #1;
        m_ready = 1'b0;
        for (int i = 0; i < 12; i++) src[8 + i] = 8'(i + 1);
        avail = 20;
        rp0 = rd_ptr;
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (m_valid && (m_data !== 32'h04030201)) bad++;
        end
        check("bp_read_count", rd_ptr - rp0, 8);
        check("bp_fifo_re_low", fifo_re, 0);
        check("bp_m_valid", m_valid, 1);
        check("bp_m_data", m_data, 32'h04030201);
        check("bp_data_stable", bad, 0);
        wlog.delete();
        @(posedge clk); #1 m_ready = 1'b1;
        repeat (20) @(negedge clk);
        check("bp_word_count", wlog.size(), 3);
        dw = (wlog.size() > 0) ? wlog[0] : 32'hDEADBEEF;
        check("bp_release_w0", dw, 32'h04030201);
        dw = (wlog.size() > 1) ? wlog[1] : 32'hDEADBEEF;
        check("bp_release_w1", dw, 32'h08070605);
        dw = (wlog.size() > 2) ? wlog[2] : 32'hDEADBEEF;
        check("bp_release_w2", dw, 32'h0C0B0A09);

        // random empty / ready toggling over 1000 bytes
        @(posedge clk); #1;
        obytes.delete(); klog.delete();
        base = rd_ptr;
        for (int i = 0; i < 1000; i++) src[base + i] = 8'($urandom);
        avail = base + 1000;
        cyc = 0;
        while (obytes.size() < 1000 && cyc < 20000) begin
            @(posedge clk); #1;
            gate_empty = ($urandom_range(0, 3) == 0);
            m_ready    = ($urandom_range(0, 2) != 0);
            cyc++;
        end
        gate_empty = 1'b0; m_ready = 1'b1;
        check("rand_byte_count", obytes.size(), 1000);
        bad = 0;
        for (int i = 0; i < 1000; i++)
            if (i >= obytes.size() || obytes[i] !== src[base + i]) bad++;
        check("rand_byte_order", bad, 0);
`ifndef PACKER_TIMEOUT_EN
        bad = 0;
        foreach (klog[i]) if (klog[i] !== 4'hF) bad++;
        check("rand_keep_full", bad, 0);
`endif

        // reset with a partial word and a held output word
        @(posedge clk); #1;
        m_ready = 1'b0;
        base = rd_ptr;
        for (int i = 0; i < 6; i++) src[base + i] = 8'(8'h11 + i);
        avail = base + 6;
        repeat (7) @(posedge clk);
        @(negedge clk);
        check("prerst_m_valid", m_valid, 1);
        check("prerst_m_data", m_data, 32'h14131211);
        @(posedge clk); #1;
        rd_rst = 1'b1;
        src[rd_ptr] = 8'hEE;
        avail = rd_ptr + 1;
        @(negedge clk);
        check("rst_fifo_re", fifo_re, 0);
        @(posedge clk); #1;
        rd_rst = 1'b0;
        avail = rd_ptr;
        @(negedge clk);
        check("postrst_m_valid", m_valid, 0);
        check("postrst_m_keep", m_keep, 0);
        @(posedge clk); #1;
        wlog.delete(); klog.delete();
        base = rd_ptr;
        for (int i = 0; i < 4; i++) src[base + i] = 8'(8'h21 + i);
        avail = base + 4;
        m_ready = 1'b1;
        repeat (12) @(negedge clk);
        check("postrst_word_count", wlog.size(), 1);
        dw = (wlog.size() > 0) ? wlog[0] : 32'hDEADBEEF;
        check("postrst_word", dw, 32'h24232221);
        kw = (klog.size() > 0) ? klog[0] : 4'h0;
        check("postrst_keep", kw, 4'hF);

        // partial word: AA, BB then FIFO empty
        @(posedge clk); #1;
        base = rd_ptr;
        src[base] = 8'hAA; src[base + 1] = 8'hBB;
        avail = base + 2;
`ifdef PACKER_TIMEOUT_EN
        first = -1; dw = '0; kw = '0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (m_valid && first < 0) begin first = k; dw = m_data; kw = m_keep; end
        end
        check("flush_cycle", first, 20);
        check("flush_data", dw, 32'h0000BBAA);
        check("flush_keep", kw, 4'b0011);
`else
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (m_valid) bad++;
        end
        check("hold_no_output", bad, 0);
        @(posedge clk); #1;
        src[avail] = 8'hCC; src[avail + 1] = 8'hDD;
        avail = avail + 2;
        first = -1; dw = '0; kw = '0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (m_valid && first < 0) begin first = k; dw = m_data; kw = m_keep; end
        end
        check("hold_complete_data", dw, 32'hDDCCBBAA);
        check("hold_complete_keep", kw, 4'hF);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
